// File: rtl/wheel_encoder_reader_pkg.sv
// Shared definitions for the wheel encoder reader: direction codes, step
// encoding and the quadrature transition decoder.
package wheel_encoder_reader_pkg;

    localparam logic [1:0] DIR_FORWARD  = 2'b10;
    localparam logic [1:0] DIR_BACKWARD = 2'b01;
    localparam logic [1:0] DIR_STOP     = 2'b00;

    // Signed two-bit step values
    localparam logic [1:0] STEP_P1 = 2'b01;
    localparam logic [1:0] STEP_M1 = 2'b11;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_e;

    // Position of an {A,B} pair along the forward cycle 00->01->11->10
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] diff;
        diff = gray_pos(cur_ab) - gray_pos(prev_ab);
        case (diff)
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            2'd2:    return STEP_ILLEGAL;
            default: return STEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wheel_encoder_reader_filter.sv
// One encoder channel: 2-FF synchroniser followed by a stability filter that
// accepts a new level only after FILT_LEN consecutive equal samples.
module wheel_encoder_reader_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic filt,
    output logic stable_c
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // Count cycles the synchronised level differs from the accepted one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stable_c = (sync2 == filt);

endmodule

// File: rtl/wheel_encoder_reader.sv
// Quadrature wheel encoder reader: filtered A/B decode into position, windowed
// velocity, direction code, stall detection and sticky illegal-transition flag.
module wheel_encoder_reader
    import wheel_encoder_reader_pkg::*;
#(
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned POS_W      = 32,
    parameter int unsigned VEL_W      = 16,
    parameter int unsigned WIN_CYCLES = 1000000,
    parameter int unsigned STALL_WINS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_en,
    input  logic             invert_dir,
    input  logic             clr_pos,
    input  logic             err_clr,
    output logic [POS_W-1:0] position,
    output logic [VEL_W-1:0] velocity,
    output logic             vel_valid,
    output logic [1:0]       dir_code,
    output logic             stalled,
    output logic             err_illegal
);

    localparam int unsigned WIN_W   = $clog2(WIN_CYCLES);
    localparam int unsigned ZC_W    = $clog2(STALL_WINS + 1);
    localparam int unsigned PRIME_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

    logic               filt_a, filt_b, stab_a, stab_b;
    logic [1:0]         cur_ab, prev_ab;
    logic               primed;
    logic [PRIME_W-1:0] prime_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [VEL_W-1:0]   acc;
    logic [ZC_W-1:0]    zero_wins;

    step_e              step_kind_c;
    logic [1:0]         step_c;
    logic               illegal_c;
    logic               win_last_c;
    logic [VEL_W:0]     acc_sum_c;
    logic [VEL_W-1:0]   acc_sat_c;
    logic [ZC_W-1:0]    zero_wins_nxt_c;

    wheel_encoder_reader_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (enc_a),
        .filt     (filt_a),
        .stable_c (stab_a)
    );

    wheel_encoder_reader_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (enc_b),
        .filt     (filt_b),
        .stable_c (stab_b)
    );

    assign cur_ab = {filt_a, filt_b};

    // Priming: first stable filtered pair becomes the reference, then prev_ab tracks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed    <= 1'b0;
            prime_cnt <= '0;
            prev_ab   <= 2'b00;
        end else if (primed) begin
            prev_ab <= cur_ab;
        end else if (!(stab_a && stab_b)) begin
            prime_cnt <= '0;
        end else if (prime_cnt == PRIME_W'(FILT_LEN - 1)) begin
            primed  <= 1'b1;
            prev_ab <= cur_ab;
        end else begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    always_comb begin
        step_kind_c     = STEP_NONE;
        step_c          = 2'b00;
        if (primed && enc_en) begin
            step_kind_c = decode_step(prev_ab, cur_ab);
        end
        case (step_kind_c)
            STEP_FWD: step_c = invert_dir ? STEP_M1 : STEP_P1;
            STEP_REV: step_c = invert_dir ? STEP_P1 : STEP_M1;
            default:  step_c = 2'b00;
        endcase
        illegal_c  = (step_kind_c == STEP_ILLEGAL);
        win_last_c = (win_cnt == WIN_W'(WIN_CYCLES - 1));
        // Accumulate one guard bit wide, then clamp to the signed VEL_W range
        acc_sum_c  = {acc[VEL_W-1], acc} + {{(VEL_W-1){step_c[1]}}, step_c};
        if (acc_sum_c[VEL_W] != acc_sum_c[VEL_W-1]) begin
            acc_sat_c = acc_sum_c[VEL_W] ? VEL_MIN : VEL_MAX;
        end else begin
            acc_sat_c = acc_sum_c[VEL_W-1:0];
        end
        zero_wins_nxt_c = (zero_wins == ZC_W'(STALL_WINS)) ? zero_wins : zero_wins + ZC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= '0;
        end else if (clr_pos) begin
            position <= '0;
        end else begin
            position <= position + {{(POS_W-2){step_c[1]}}, step_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else if (illegal_c) begin
            err_illegal <= 1'b1;
        end else if (err_clr) begin
            err_illegal <= 1'b0;
        end
    end

    // Velocity window, direction and stall tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
            zero_wins <= '0;
            stalled   <= 1'b0;
            dir_code  <= DIR_STOP;
        end else if (!enc_en) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
            zero_wins <= '0;
            stalled   <= 1'b0;
            dir_code  <= DIR_STOP;
        end else begin
            vel_valid <= 1'b0;
            if (step_c == STEP_P1) begin
                dir_code <= DIR_FORWARD;
            end else if (step_c == STEP_M1) begin
                dir_code <= DIR_BACKWARD;
            end
            if (win_last_c) begin
                win_cnt   <= '0;
                acc       <= '0;
                velocity  <= acc_sat_c;
                vel_valid <= 1'b1;
                if (acc_sat_c == '0) begin
                    dir_code  <= DIR_STOP;
                    zero_wins <= zero_wins_nxt_c;
                    stalled   <= (zero_wins_nxt_c == ZC_W'(STALL_WINS));
                end else begin
                    zero_wins <= '0;
                    stalled   <= 1'b0;
                end
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                acc     <= acc_sat_c;
            end
        end
    end

endmodule

// File: tb/tb_wheel_encoder_reader.sv
// Bench for wheel_encoder_reader: decode vector table, directed corner-case
// sequences and a randomized run against a window/step reference model.
module tb_wheel_encoder_reader;

    localparam int unsigned FILT_LEN   = 4;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned VEL_W      = 8;
    localparam int unsigned WIN_CYCLES = 1000;
    localparam int unsigned STALL_WINS = 3;
    localparam int          LAT        = FILT_LEN + 3;
    localparam int          RUN_LEN    = 6000;

    logic             clk = 1'b0;
    logic             rst_n, enc_a, enc_b, enc_en, invert_dir, clr_pos, err_clr;
    logic [POS_W-1:0] position;
    logic [VEL_W-1:0] velocity;
    logic             vel_valid;
    logic [1:0]       dir_code;
    logic             stalled, err_illegal;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int gi    = 0;
    logic [1:0] gray [4];

    typedef struct {
        logic [1:0] prev;
        logic [1:0] cur;
        logic       inv;
        int         exp_pos;
        logic       exp_err;
    } dec_vec_t;

    dec_vec_t dv [14];

    wheel_encoder_reader #(
        .FILT_LEN   (FILT_LEN),
        .POS_W      (POS_W),
        .VEL_W      (VEL_W),
        .WIN_CYCLES (WIN_CYCLES),
        .STALL_WINS (STALL_WINS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .enc_en      (enc_en),
        .invert_dir  (invert_dir),
        .clr_pos     (clr_pos),
        .err_clr     (err_clr),
        .position    (position),
        .velocity    (velocity),
        .vel_valid   (vel_valid),
        .dir_code    (dir_code),
        .stalled     (stalled),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_until(input int tt);
        while (t < tt) tick();
    endtask

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
    endtask

    task automatic move(input int d);
        gi = (gi + d + 4) % 4;
        set_ab(gray[gi]);
    endtask

    // Reset with pins parked at ab; t counts clock edges after release
    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        rst_n = 1'b0; set_ab(ab); enc_en = 1'b1; invert_dir = 1'b0;
        clr_pos = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        gi = 0;
    endtask

    task automatic count_vv(input int until_t, output int pulses);
        pulses = 0;
        while (t < until_t) begin
            tick();
            if (vel_valid === 1'b1) pulses++;
        end
    endtask

    function automatic int wrap_pos(input int p);
        int m;
        m = ((p % 256) + 256) % 256;
        return (m > 127) ? m - 256 : m;
    endfunction

    function automatic int clamp_vel(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Random moves scheduled ahead; model derives step timing from the pin-to-count latency
    task automatic run_random(input logic inv, input int seg);
        int mv [RUN_LEN];
        int es [RUN_LEN + 16];
        int act [6];
        int last, gap, w, s, mpos, macc, mvel, mdir, mzc;
        logic mvv;
        for (int i = 0; i < RUN_LEN; i++) mv[i] = 0;
        for (int i = 0; i < RUN_LEN + 16; i++) es[i] = 0;
        for (int i = 0; i < 6; i++) begin
            if (seg == 0) act[i] = (i >= 1 && i <= 3) ? 0 : 35;
            else          act[i] = (($urandom_range(2, 0) == 0) ? 0 : 40);
        end
        last = -100; gap = 5;
        for (int tt = 20; tt < RUN_LEN - 10; tt++) begin
            w = tt / 1000;
            if ((tt % 1000) < 990 && tt - last >= gap && $urandom_range(99, 0) < act[w]) begin
                mv[tt] = ($urandom_range(1, 0) == 1) ? 1 : -1;
                es[tt + LAT] = inv ? -mv[tt] : mv[tt];
                last = tt;
                gap = $urandom_range(12, 5);
            end
        end
        do_reset(2'b00);
        invert_dir = inv;
        mpos = 0; macc = 0; mvel = 0; mdir = 0; mzc = 0;
        for (int k = 1; k <= RUN_LEN; k++) begin
            if (mv[t] != 0) move(mv[t]);
            tick();
            s = es[k];
            mpos += s;
            if (s > 0) mdir = 2;
            else if (s < 0) mdir = 1;
            macc = clamp_vel(macc + s);
            mvv = 1'b0;
            if (k % 1000 == 0) begin
                mvel = macc; macc = 0; mvv = 1'b1;
                if (mvel == 0) begin mdir = 0; mzc++; end
                else mzc = 0;
            end
            chk("rnd_pos", $signed(position), wrap_pos(mpos));
            chk("rnd_vel", $signed(velocity), mvel);
            chk("rnd_vv", vel_valid, mvv);
            chk("rnd_dir", dir_code, mdir);
            chk("rnd_stall", stalled, (mzc >= 3) ? 1 : 0);
        end
    endtask

    initial begin
        int pulses;
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        dv[0]  = '{2'b00, 2'b01, 1'b0,  1, 1'b0};
        dv[1]  = '{2'b01, 2'b11, 1'b0,  1, 1'b0};
        dv[2]  = '{2'b11, 2'b10, 1'b0,  1, 1'b0};
        dv[3]  = '{2'b10, 2'b00, 1'b0,  1, 1'b0};
        dv[4]  = '{2'b00, 2'b10, 1'b0, -1, 1'b0};
        dv[5]  = '{2'b10, 2'b11, 1'b0, -1, 1'b0};
        dv[6]  = '{2'b11, 2'b01, 1'b0, -1, 1'b0};
        dv[7]  = '{2'b01, 2'b00, 1'b0, -1, 1'b0};
        dv[8]  = '{2'b00, 2'b01, 1'b1, -1, 1'b0};
        dv[9]  = '{2'b11, 2'b01, 1'b1,  1, 1'b0};
        dv[10] = '{2'b00, 2'b11, 1'b0,  0, 1'b1};
        dv[11] = '{2'b01, 2'b10, 1'b1,  0, 1'b1};
        dv[12] = '{2'b11, 2'b11, 1'b0,  0, 1'b0};
        dv[13] = '{2'b10, 2'b10, 1'b1,  0, 1'b0};

        rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_en = 1'b1;
        invert_dir = 1'b0; clr_pos = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pos", $signed(position), 0);
        chk("rst_vel", $signed(velocity), 0);
        chk("rst_vv", vel_valid, 0);
        chk("rst_dir", dir_code, 0);
        chk("rst_stall", stalled, 0);
        chk("rst_err", err_illegal, 0);

        // Decode table: priming on a parked pair, then one filtered transition
        for (int i = 0; i < 14; i++) begin
            do_reset(dv[i].prev);
            wait_n(20);
            invert_dir = dv[i].inv;
            set_ab(dv[i].cur);
            wait_n(12);
            chk("tbl_pos", $signed(position), dv[i].exp_pos);
            chk("tbl_err", err_illegal, dv[i].exp_err);
        end

        // Forward count and exact pin-to-count latency
        do_reset(2'b00);
        wait_until(20);
        move(1);
        wait_n(LAT - 1);
        chk("lat_before", $signed(position), 0);
        tick();
        chk("lat_at", $signed(position), 1);
        wait_until(40);
        repeat (99) begin move(1); wait_n(20); end
        chk("fwd_pos", $signed(position), 100);
        chk("fwd_dir", dir_code, 2);

        // Reverse with and without inversion
        do_reset(2'b00);
        wait_until(20);
        invert_dir = 1'b1;
        repeat (40) begin move(-1); wait_n(10); end
        wait_n(10);
        chk("rev_inv_pos", $signed(position), 40);
        chk("rev_inv_dir", dir_code, 2);
        do_reset(2'b00);
        wait_until(20);
        repeat (40) begin move(-1); wait_n(10); end
        wait_n(10);
        chk("rev_pos", $signed(position), -40);
        chk("rev_dir", dir_code, 1);

        // Velocity window, terminal-cycle edge, stall and recovery
        do_reset(2'b00);
        for (int i = 0; i < 49; i++) begin wait_until(20 + 19 * i); move(1); end
        wait_until(1000 - LAT);
        move(1);
        wait_until(999);
        chk("vel_vv_early", vel_valid, 0);
        tick();
        chk("vel_vv", vel_valid, 1);
        chk("vel_val", $signed(velocity), 50);
        tick();
        chk("vel_vv_once", vel_valid, 0);
        wait_until(1999);
        chk("dir_hold", dir_code, 2);
        tick();
        chk("dir_stop", dir_code, 0);
        wait_until(3999);
        chk("stall_early", stalled, 0);
        tick();
        chk("stall_set", stalled, 1);
        wait_until(4100);
        move(1);
        wait_until(4999);
        chk("stall_hold", stalled, 1);
        tick();
        chk("stall_clr", stalled, 0);
        chk("stall_vel", $signed(velocity), 1);

        // Glitch rejection and illegal-transition flag
        do_reset(2'b00);
        wait_until(20);
        enc_a = 1'b1; wait_n(3); enc_a = 1'b0;
        wait_n(15);
        chk("glitch_pos", $signed(position), 0);
        chk("glitch_err", err_illegal, 0);
        set_ab(2'b11);
        wait_n(12);
        chk("ill_pos", $signed(position), 0);
        chk("ill_err", err_illegal, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        chk("errclr", err_illegal, 0);
        set_ab(2'b00);
        wait_n(LAT - 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill_clr_same", err_illegal, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        chk("errclr2", err_illegal, 0);

        // Position wrap, clr_pos colliding with a step, velocity saturation
        do_reset(2'b00);
        wait_until(20);
        repeat (127) begin move(1); wait_n(6); end
        wait_n(10);
        chk("pos_max", $signed(position), 127);
        move(1);
        wait_n(10);
        chk("pos_wrap", $signed(position), -128);
        move(1);
        wait_n(LAT - 1);
        clr_pos = 1'b1; tick(); clr_pos = 1'b0;
        chk("clr_step", $signed(position), 0);
        wait_n(5);
        chk("clr_hold", $signed(position), 0);
        do_reset(2'b00);
        wait_until(10);
        repeat (300) begin move(1); wait_n(3); end
        wait_until(1000);
        chk("sat_vv", vel_valid, 1);
        chk("sat_vel", $signed(velocity), 127);
        chk("sat_pos", $signed(position), 44);

        // enc_en drop and re-enable
        do_reset(2'b00);
        wait_until(20);
        repeat (5) begin move(1); wait_n(10); end
        wait_until(500);
        enc_en = 1'b0;
        tick();
        chk("dis_pos", $signed(position), 5);
        chk("dis_dir", dir_code, 0);
        chk("dis_vel", $signed(velocity), 0);
        wait_until(510); move(1);
        wait_until(530); move(1);
        count_vv(1100, pulses);
        chk("dis_no_vv", pulses, 0);
        chk("dis_hold", $signed(position), 5);
        chk("dis_stall", stalled, 0);
        wait_until(1500);
        enc_en = 1'b1;
        wait_n(20);
        chk("reen_nostep", $signed(position), 5);
        wait_until(1600);
        move(1);
        wait_n(10);
        chk("reen_step", $signed(position), 6);
        wait_until(2499);
        chk("reen_vv_early", vel_valid, 0);
        tick();
        chk("reen_vv", vel_valid, 1);
        chk("reen_vel", $signed(velocity), 1);

        // Reset in the middle of a window
        do_reset(2'b00);
        wait_until(20);
        repeat (3) begin move(1); wait_n(10); end
        set_ab(gray[(gi + 2) % 4]);
        wait_n(12);
        chk("mid_err_pre", err_illegal, 1);
        wait_until(700);
        rst_n = 1'b0;
        #1;
        chk("mid_pos", $signed(position), 0);
        chk("mid_vel", $signed(velocity), 0);
        chk("mid_vv", vel_valid, 0);
        chk("mid_dir", dir_code, 0);
        chk("mid_stall", stalled, 0);
        chk("mid_err", err_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        count_vv(300, pulses);
        chk("mid_no_vv", pulses, 0);
        chk("mid_pos_after", $signed(position), 0);

        run_random(1'b0, 0);
        run_random(1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
